cache_mem_array: RTL

//   Parametrised single-port storage array for cache data, tag, valid and dirty fields.

---
 rtl/cache_mem_pkg.sv | 20 ++
 rtl/cache_mem_array_core.sv | 38 +++
 rtl/cache_mem_array.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache storage arrays.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_mem_pkg;

    // Sequencer state: clearing the array, or serving accesses.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Value every cache field array is wiped to unless an instance overrides it.
    localparam int CLEAR_VAL_DEFAULT = 0;

    // Index of the last entry in an array addressed by addr_w bits.
    function automatic int last_index(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/cache_mem_array_core.sv
// Plain storage: one write port and one registered read port.
// Latency: write lands on the edge; read data appears 1 cycle after re.
// Backpressure: none; the caller arbitrates between clear and user traffic.
module mem_array_core #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rclr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Single write port; contents are not reset, the clear sequence owns that.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; rclr forces the output to zero and wins over a read.
    always_ff @(posedge clk) begin
        if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cache_mem_array.sv
// Cache field array with a self-clearing sequencer and registered reads.
// Latency: read data and data_valid 1 cycle after an accepted read.
// Backpressure: ready low while clearing (DEPTH cycles after reset or init_req).
module cache_mem_array
    import cache_mem_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_W    = 5,
    parameter logic [WIDTH-1:0] CLEAR_VAL = WIDTH'(CLEAR_VAL_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              init_req,
    output logic              ready,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_valid
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(last_index(ADDR_W));

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;

    logic              clearing;
    logic              flush;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_re;
    logic              mem_rclr;

    // An access only counts when the array is idle and no flush shares the cycle.
    // Gating with en first keeps X on write/addr/data_in away from the array.
    always_comb begin
        clearing = (state == ST_CLEAR);
        flush    = ready & init_req;
        acc      = en & ready & ~init_req;
        wr_acc   = acc & write;
        rd_acc   = acc & ~write;
    end

    // Steer the single write port between the clear sequencer and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = data_in;
        if (!rst) begin
            if (clearing) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = CLEAR_VAL;
            end else begin
                mem_we    = wr_acc;
            end
        end
    end

    // Read port: reads only when accepted; reset, writes and flushes zero the output.
    always_comb begin
        mem_re   = ~rst & rd_acc;
        mem_rclr = rst | wr_acc | flush;
    end

    mem_array_core #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (addr),
        .rclr  (mem_rclr),
        .rdata (data_out)
    );

    // Sequencer: walk every entry once, then serve accesses until a flush.
    // The pointer wraps naturally to zero on the terminal edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            ready      <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr    <= clr_ptr + ADDR_W'(1);
                    data_valid <= 1'b0;
                    if (clr_ptr == LAST_IDX) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (init_req) begin
                        state      <= ST_CLEAR;
                        clr_ptr    <= '0;
                        ready      <= 1'b0;
                        data_valid <= 1'b0;
                    end else begin
                        data_valid <= rd_acc;
                    end
                end
                default: begin
                    state      <= ST_CLEAR;
                    clr_ptr    <= '0;
                    ready      <= 1'b0;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
